// File: rtl/ft_pkg.sv
// ============================================================================
// ft_pkg : shared types and default widths for the ft_system restore path
// Revision 1.0
// ============================================================================
`default_nettype none

package ft_pkg;

  localparam int FT_ADDR_WIDTH = 5;
  localparam int FT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } ft_restore_state_t;

endpackage

`default_nettype wire

// File: rtl/ft_sweep_ctr.sv
// ============================================================================
// ft_sweep_ctr : wrapping bank pointer plus remaining-entry down-counter
// Revision 1.0
// ============================================================================
`default_nettype none

module ft_sweep_ctr
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  last
);

  // One extra bit so the full bank depth is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH:0]   remaining_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      remaining_q <= '0;
    end else if (load) begin
      ptr_q       <= load_addr;
      remaining_q <= DEPTH;
    end else if (step) begin
      ptr_q       <= ptr_q + 1'b1;
      remaining_q <= remaining_q - ONE;
    end
  end

  assign ptr  = ptr_q;
  assign last = (remaining_q == ONE);

endmodule

`default_nettype wire

// File: rtl/ft_restore_reader.sv
// ============================================================================
// ft_restore_reader : replays golden checkpoint words into both bank copies,
// sweeping from the faulting address around the whole bank. Revision 1.0
// ============================================================================
`default_nettype none

module ft_restore_reader
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_block_i,
  input  logic [ADDR_WIDTH-1:0] err_addr_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rvalid_i,
  input  logic                  wr_ready_i,
  output logic                  we_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  ft_restore_state_t     state_q, state_d;
  logic                  fetch_q;
  logic                  start;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ctr_load;
  logic                  ctr_step;
  logic                  ctr_last;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  we;

  assign start = fetch_block_i & ~fetch_q;

  ft_sweep_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sweep_ctr (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .load      (ctr_load),
    .load_addr (err_addr_i),
    .step      (ctr_step),
    .ptr       (ptr),
    .last      (ctr_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      fetch_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_block_i;
      if (state_q == ST_WAIT && mem_rvalid_i) begin
        data_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ctr_load   = 1'b0;
    ctr_step   = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    we         = 1'b0;
    addr_o     = '0;
    data_o     = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ctr_load = 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = ptr;
        busy_o     = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        if (mem_rvalid_i) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy_o = 1'b1;
        we     = 1'b1;
        addr_o = ptr;
        data_o = data_q;
        if (wr_ready_i) begin
          ctr_step = 1'b1;
          state_d  = ctr_last ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A single enable feeds both copies so a one-sided write cannot occur.
  assign we_a_o = we;
  assign we_b_o = we;

endmodule

`default_nettype wire

// File: tb/tb_ft_restore_reader.sv
// ============================================================================
// tb_ft_restore_reader : randomized bench with a sweep-order reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ft_restore_reader;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          fetch_block_i = 1'b0;
  logic [AW-1:0] err_addr_i = '0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_rvalid_i = 1'b0;
  logic          wr_ready_i = 1'b1;
  logic          we_a_o;
  logic          we_b_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic          busy_o;
  logic          done_o;

  ft_restore_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_block_i (fetch_block_i),
    .err_addr_i    (err_addr_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .wr_ready_i    (wr_ready_i),
    .we_a_o        (we_a_o),
    .we_b_o        (we_b_o),
    .addr_o        (addr_o),
    .data_o        (data_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [DEPTH];
  bit            rnd_mode = 1'b0;

  int            cyc = 0;
  int            start_cyc = 0;
  int            first_req_cyc = 0;
  bit            req_seen = 1'b0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            side_err = 0;
  int            stab_err = 0;
  bit            prev_hold = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] log_a[$];
  logic [DW-1:0] log_d[$];

  always @(posedge clk_i) cyc = cyc + 1;

  // Observe the write port and handshake away from the clock edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_hold = 1'b0;
    end else begin
      if (we_a_o !== we_b_o) side_err = side_err + 1;
      if (prev_hold && (we_a_o !== 1'b1 || addr_o !== prev_addr || data_o !== prev_data))
        stab_err = stab_err + 1;
      if (we_a_o === 1'b1 && wr_ready_i) begin
        log_a.push_back(addr_o);
        log_d.push_back(data_o);
      end
      prev_hold = (we_a_o === 1'b1) && !wr_ready_i;
      prev_addr = addr_o;
      prev_data = data_o;
      if (done_o === 1'b1) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (mem_req_o === 1'b1 && !req_seen) begin
        first_req_cyc = cyc;
        req_seen      = 1'b1;
      end
    end
  end

  // Checkpoint memory responder: data returns 1..5 cycles after a request.
  initial begin
    forever begin
      @(negedge clk_i);
      if (mem_req_o === 1'b1) begin
        automatic logic [AW-1:0] a = mem_addr_o;
        automatic int d = rnd_mode ? $urandom_range(1, 5) : 1;
        @(posedge clk_i);
        repeat (d - 1) begin
          #1 mem_rdata_i = $urandom;
          @(posedge clk_i);
        end
        #1 mem_rvalid_i = 1'b1;
        mem_rdata_i = mem[a];
        @(posedge clk_i);
        #1 mem_rvalid_i = 1'b0;
        mem_rdata_i = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1 wr_ready_i = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_sweep(input logic [AW-1:0] e);
    @(posedge clk_i);
    #1;
    log_a.delete();
    log_d.delete();
    req_seen      = 1'b0;
    err_addr_i    = e;
    fetch_block_i = 1'b1;
    start_cyc     = cyc;
    @(posedge clk_i);
    #1 err_addr_i = AW'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    timed_out = (done_cnt == d0);
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #3;
    total++;
    if ({busy_o, done_o, mem_req_o, we_a_o, we_b_o, addr_o, mem_addr_o, data_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b req=%b we=%b%b addr=%0h maddr=%0h data=%0h want all 0",
               busy_o, done_o, mem_req_o, we_a_o, we_b_o, addr_o, mem_addr_o, data_o);
    end
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b req=%b want 0 0", busy_o, mem_req_o);
    end
  endtask

  task automatic test_basic;
    bit to;
    int d0 = done_cnt;
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 10);
    rnd_mode = 1'b0;
    side_err = 0;
    start_sweep(AW'(10));
    wait_done(400, to);
    fetch_block_i = 1'b0;
    total++;
    if (to) begin
      bad++;
      $display("FAIL basic_timeout: got no done want done");
    end
    total++;
    if (first_req_cyc - start_cyc !== 1) begin
      bad++;
      $display("FAIL basic_req_latency: got %0d want 1", first_req_cyc - start_cyc);
    end
    total++;
    if (done_cyc - start_cyc !== 97) begin
      bad++;
      $display("FAIL basic_done_cycle: got %0d want 97", done_cyc - start_cyc);
    end
    total++;
    if (log_a.size() !== DEPTH) begin
      bad++;
      $display("FAIL basic_write_count: got %0d want %0d", log_a.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH && k < log_a.size(); k++) begin
      logic [AW-1:0] ea = AW'((10 + k) % DEPTH);
      if (log_a[k] !== ea || log_d[k] !== DW'(int'(ea) * 10)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL basic_sequence: got %0d wrong entries want 0", errs);
    end
    total++;
    if (done_cnt - d0 !== 1 || side_err !== 0) begin
      bad++;
      $display("FAIL basic_done_sides: got done=%0d sideerr=%0d want 1 0", done_cnt - d0, side_err);
    end
  endtask

  task automatic test_wrap;
    bit to;
    rnd_mode = 1'b0;
    start_sweep(AW'(31));
    wait_done(400, to);
    fetch_block_i = 1'b0;
    total++;
    if (to || log_a.size() < 2) begin
      bad++;
      $display("FAIL wrap_complete: got timeout=%0d writes=%0d want 0 >=2", to, log_a.size());
    end else begin
      total++;
      if (log_a[0] !== AW'(31) || log_d[0] !== DW'(310)) begin
        bad++;
        $display("FAIL wrap_first: got addr=%0d data=%0d want 31 310", log_a[0], log_d[0]);
      end
      total++;
      if (log_a[1] !== AW'(0) || log_d[1] !== DW'(0)) begin
        bad++;
        $display("FAIL wrap_second: got addr=%0d data=%0d want 0 0", log_a[1], log_d[1]);
      end
    end
  endtask

  task automatic test_backpressure(input int iter);
    bit to;
    int seen[DEPTH];
    int errs = 0;
    int dup = 0;
    logic [AW-1:0] e = AW'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = $urandom;
      seen[i] = 0;
    end
    rnd_mode = 1'b1;
    stab_err = 0;
    side_err = 0;
    start_sweep(e);
    wait_done(3000, to);
    fetch_block_i = 1'b0;
    rnd_mode = 1'b0;
    total++;
    if (to || log_a.size() !== DEPTH) begin
      bad++;
      $display("FAIL bp%0d_count: got timeout=%0d writes=%0d want 0 %0d", iter, to, log_a.size(), DEPTH);
    end
    for (int k = 0; k < log_a.size(); k++) begin
      logic [AW-1:0] ea = AW'((int'(e) + k) % DEPTH);
      seen[log_a[k]]++;
      if (log_a[k] !== ea || log_d[k] !== mem[ea]) errs++;
    end
    for (int i = 0; i < DEPTH; i++) if (seen[i] != 1) dup++;
    total++;
    if (errs != 0 || dup != 0) begin
      bad++;
      $display("FAIL bp%0d_data: got wrong=%0d not_once=%0d want 0 0", iter, errs, dup);
    end
    total++;
    if (stab_err != 0 || side_err != 0) begin
      bad++;
      $display("FAIL bp%0d_stable: got unstable=%0d sideerr=%0d want 0 0", iter, stab_err, side_err);
    end
  endtask

  task automatic test_retrigger;
    bit to;
    int d0 = done_cnt;
    int busy_seen = 0;
    rnd_mode = 1'b0;
    start_sweep(AW'(7));
    repeat (20) @(posedge clk_i);
    #1 fetch_block_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 fetch_block_i = 1'b1;
    wait_done(400, to);
    total++;
    if (to || done_cnt - d0 !== 1 || log_a.size() !== DEPTH || log_a[0] !== AW'(7)) begin
      bad++;
      $display("FAIL retrigger_single: got timeout=%0d done=%0d writes=%0d want 0 1 %0d",
               to, done_cnt - d0, log_a.size(), DEPTH);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0 || mem_req_o !== 1'b0) busy_seen++;
    end
    total++;
    if (busy_seen != 0 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL held_high_no_restart: got busy_cycles=%0d done=%0d want 0 1", busy_seen, done_cnt - d0);
    end
    fetch_block_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit to;
    int n = 0;
    int d0 = done_cnt;
    int errs = 0;
    rnd_mode = 1'b0;
    start_sweep(AW'($urandom));
    while (log_a.size() < 5 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    total++;
    if (log_a.size() < 5) begin
      bad++;
      $display("FAIL midreset_progress: got %0d writes want 5", log_a.size());
    end
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    total++;
    if ({busy_o, done_o, mem_req_o, we_a_o, we_b_o, addr_o, mem_addr_o, data_o} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got busy=%b req=%b we=%b%b addr=%0h data=%0h want all 0",
               busy_o, mem_req_o, we_a_o, we_b_o, addr_o, data_o);
    end
    fetch_block_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_cnt !== d0) begin
      bad++;
      $display("FAIL midreset_abort: got busy=%b done=%0d want 0 0", busy_o, done_cnt - d0);
    end
    start_sweep(AW'(3));
    wait_done(400, to);
    fetch_block_i = 1'b0;
    for (int k = 0; k < DEPTH && k < log_a.size(); k++) begin
      logic [AW-1:0] ea = AW'((3 + k) % DEPTH);
      if (log_a[k] !== ea || log_d[k] !== mem[ea]) errs++;
    end
    total++;
    if (to || log_a.size() !== DEPTH || errs != 0) begin
      bad++;
      $display("FAIL midreset_fresh_sweep: got timeout=%0d writes=%0d wrong=%0d want 0 %0d 0",
               to, log_a.size(), errs, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    for (int i = 0; i < 3; i++) test_backpressure(i);
    test_retrigger();
    test_reset_mid();
    repeat (5) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ft_restore_reader.md
Name: ft_restore_reader

Overview:
- Recovery-side counterpart of the ft_system mismatch detector.
- On each rising edge of fetch_block, reads the golden copy of every register-bank entry from checkpoint memory.
- Replays each entry as a lockstep write to both redundant copies (port A and port B).
- The sweep starts at the faulting address and wraps, so the corrupted entry is repaired first.

Parameters:
- ADDR_WIDTH, 5, bank address width; bank depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- fetch_block_i  in  1  mismatch flag from detector; level, edge-detected internally.
- err_addr_i  in  ADDR_WIDTH  faulting address; sampled on fetch_block_i rising edge.
- mem_req_o  in→out  1  one-cycle checkpoint read request.
- mem_addr_o  out  ADDR_WIDTH  checkpoint read address.
- mem_rdata_i  in  DATA_WIDTH  checkpoint read data.
- mem_rvalid_i  in  1  read data valid, ≥1 cycle after mem_req_o.
- wr_ready_i  in  1  both bank copies accept the write this cycle.
- we_a_o  out  1  restore write enable, copy A.
- we_b_o  out  1  restore write enable, copy B.
- addr_o  out  ADDR_WIDTH  restore address, shared by A and B.
- data_o  out  DATA_WIDTH  restore data, shared by A and B.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; edge-detect register 0; counters 0.
- Edge detect: start = fetch_block_i & ~fetch_block_q. Level held high causes no retrigger.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on start, capture ptr=err_addr_i, remaining=2**ADDR_WIDTH; goto READ.
- READ (1 cycle): mem_req_o=1, mem_addr_o=ptr, busy_o=1; goto WAIT.
- WAIT: busy_o=1. On mem_rvalid_i, register mem_rdata_i into data reg; goto WRITE.
- WRITE: we_a_o=we_b_o=1, addr_o=ptr, data_o=data reg, held stable until wr_ready_i.
  - Transfer on a cycle with wr_ready_i=1.
  - Then ptr=ptr+1 (mod 2**ADDR_WIDTH) and remaining-1.
  - If remaining was 1, goto DONE; else goto READ.
- DONE (1 cycle): done_o=1, busy_o=0; goto IDLE.
- we_a_o and we_b_o are always identical; no single-sided write ever occurs.
- Outside WRITE: addr_o, data_o, we_*=0. Outside READ: mem_req_o=0, mem_addr_o=0.
- Timing: start sampled at edge N gives mem_req_o high in cycle N+1.
  - Best case per entry: 3 cycles (rvalid the cycle after req, wr_ready_i already high).
  - Full sweep minimum: 3·2**ADDR_WIDTH + 1 cycles including DONE.
- Boundaries:
  - Wrap: ptr counts 31→0 (default params). Every address is written exactly once per sweep.
  - fetch_block_i edges while busy or in DONE are ignored, not queued. fetch_block_q still tracks the input.
  - mem_rvalid_i outside WAIT is ignored.
  - mem_rvalid_i in the same cycle as mem_req_o is not possible by contract.
  - Reset mid-sweep: immediate abort, outputs 0. No done_o pulse. A new edge is required afterwards.
  - err_addr_i is don't-care except at the start edge.

Decomposition:
- ft_pkg holds the state enum type (ft_restore_state_t) and the default ADDR_WIDTH/DATA_WIDTH constants, shared with ft_system.
- One sub-module, ft_sweep_ctr: loadable wrapping address pointer plus remaining-entry down-counter with a last flag. The FSM and datapath stay in the top module.

Test Plan:
- Reset: assert rst_ni=0 mid-clock → all outputs 0 asynchronously. Release; fetch_block_i stays 0 → stays IDLE, busy_o=0.
- Basic sweep: memory[i]=i*10; rvalid 1 cycle after req; wr_ready_i=1; fetch_block_i rises with err_addr_i=10.
  - Writes run at addr 10..31, 0..9, data=addr*10.
  - done_o pulses at cycle 97 after the start edge. Exactly 32 writes occur, each with we_a_o=we_b_o.
- Wrap/first entry: err_addr_i=31 → first write is addr 31, data 310; second is addr 0, data 0.
- Backpressure/latency: random rvalid delay 1–5 cycles, random wr_ready_i.
  - addr_o/data_o/we_* stay stable while wr_ready_i=0.
  - Each address is written once; golden data matches the memory model.
- Retrigger: drop and re-raise fetch_block_i mid-sweep → ignored; one done_o. Holding it high after done → no new sweep.
- Reset mid-sweep at entry 5: outputs 0, no done_o. New rising edge with err_addr_i=3 → fresh 32-entry sweep starting at 3.
